// File: rtl/adder_share_sched_pkg.sv
// Shared definitions for the adder time-sharing scheduler.
//   state_t  : scheduler FSM state encoding (3-bit)
//   op_t     : latched 64-bit operand pair of the accepted request
//   OP_W     : full operand width
//   HALF_W   : width of one pass through the shared adder
package adder_share_sched_pkg;

    localparam int OP_W   = 64;
    localparam int HALF_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADD_LO = 3'd1,
        ADD_HI = 3'd2,
        ADD_CI = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_t;

endpackage

// File: rtl/adder_share_sched_adder.sv
// 32-bit adder without carry input; the one instance the scheduler owns.
//   in_1, in_2 : addends
//   out_put    : sum mod 2^32
//   carry_out  : carry out of bit 31
module adder_32bit
    import adder_share_sched_pkg::*;
(
    input  logic [HALF_W-1:0] in_1,
    input  logic [HALF_W-1:0] in_2,
    output logic [HALF_W-1:0] out_put,
    output logic              carry_out
);

    assign {carry_out, out_put} = {1'b0, in_1} + {1'b0, in_2};

endmodule

// File: rtl/adder_share_sched.sv
// Time-shares one 32-bit adder among NUM_REQ requesters. Each accepted
// request is a 64-bit add done as a low pass, a high pass and, when the
// low pass carried, an extra +1 pass on the high half.
//   clk, reset   : clock, synchronous active-high reset
//   req_valid    : per-requester request valid
//   req_a, req_b : per-requester 64-bit operands (requester i in slot i)
//   req_ready    : one-hot accept strobe, combinational in IDLE
//   resp_valid   : one-hot, one-cycle result strobe (DONE state)
//   resp_sum     : A+B mod 2^64, held until the next result
//   resp_cout    : carry out of bit 63
//   resp_id      : requester being answered
//   busy         : high whenever an operation is in flight
module adder_share_sched
    import adder_share_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_a,
    input  logic [NUM_REQ-1:0][OP_W-1:0]  req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [OP_W-1:0]               resp_sum,
    output logic                          resp_cout,
    output logic [ID_W-1:0]               resp_id,
    output logic                          busy
);

    state_t              state;
    op_t                 op;
    logic [ID_W-1:0]     id;
    logic [ID_W-1:0]     last_grant;
    logic [HALF_W-1:0]   sum_lo;
    logic [HALF_W-1:0]   sum_hi;
    logic                c_lo;
    logic                c_hi;

    logic [HALF_W-1:0]   add_a;
    logic [HALF_W-1:0]   add_b;
    logic [HALF_W-1:0]   add_sum;
    logic                add_co;

    logic [ID_W:0]       pick;
    logic [ID_W-1:0]     pick_id;

    // Round-robin pick: rotate the valid vector so the slot after last
    // comes first, priority-encode the lowest set bit, rotate the offset
    // back. Returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_REQ-1:0] vld,
        input logic [ID_W-1:0]    last
    );
        logic [2*NUM_REQ-1:0] dbl;
        logic [NUM_REQ-1:0]   rot;
        int                   off;
        int                   idx;
        dbl = {vld, vld} >> (int'(last) + 1);
        rot = dbl[NUM_REQ-1:0];
        off = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        idx = (int'(last) + 1 + off) % NUM_REQ;
        return {|vld, ID_W'(idx)};
    endfunction

    assign pick    = rr_pick(req_valid, last_grant);
    assign pick_id = pick[ID_W-1:0];
    assign busy    = (state != IDLE);

    // Accept is suppressed while reset is high so a requester never sees
    // a grant that the reset edge would discard.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset && pick[ID_W]) req_ready[pick_id] = 1'b1;
    end

    // Adder input mux; inputs are held at 0 outside the add passes.
    always_comb begin
        add_a = '0;
        add_b = '0;
        case (state)
            ADD_LO: begin
                add_a = op.a[HALF_W-1:0];
                add_b = op.b[HALF_W-1:0];
            end
            ADD_HI: begin
                add_a = op.a[OP_W-1:HALF_W];
                add_b = op.b[OP_W-1:HALF_W];
            end
            ADD_CI: begin
                add_a = sum_hi;
                add_b = HALF_W'(1);
            end
            default: ;
        endcase
    end

    adder_32bit u_adder (
        .in_1      (add_a),
        .in_2      (add_b),
        .out_put   (add_sum),
        .carry_out (add_co)
    );

    // Response registers are loaded on the edge entering DONE so they are
    // valid for the whole DONE cycle and hold afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op         <= '0;
            id         <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
            sum_lo     <= '0;
            sum_hi     <= '0;
            c_lo       <= 1'b0;
            c_hi       <= 1'b0;
            resp_valid <= '0;
            resp_sum   <= '0;
            resp_cout  <= 1'b0;
            resp_id    <= '0;
        end else begin
            resp_valid <= '0;
            case (state)
                IDLE: begin
                    if (pick[ID_W]) begin
                        op.a  <= req_a[pick_id];
                        op.b  <= req_b[pick_id];
                        id    <= pick_id;
                        state <= ADD_LO;
                    end
                end
                ADD_LO: begin
                    sum_lo <= add_sum;
                    c_lo   <= add_co;
                    state  <= ADD_HI;
                end
                ADD_HI: begin
                    sum_hi <= add_sum;
                    c_hi   <= add_co;
                    if (c_lo) begin
                        state <= ADD_CI;
                    end else begin
                        state          <= DONE;
                        resp_valid[id] <= 1'b1;
                        resp_sum       <= {add_sum, sum_lo};
                        resp_cout      <= add_co;
                        resp_id        <= id;
                    end
                end
                ADD_CI: begin
                    // sum_hi + 1 can only carry when sum_hi was all ones,
                    // which rules out a carry from the high pass itself.
                    sum_hi         <= add_sum;
                    c_hi           <= c_hi | add_co;
                    state          <= DONE;
                    resp_valid[id] <= 1'b1;
                    resp_sum       <= {add_sum, sum_lo};
                    resp_cout      <= c_hi | add_co;
                    resp_id        <= id;
                end
                DONE: begin
                    last_grant <= id;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_sched.sv
module tb_adder_share_sched;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req_valid;
    logic [N-1:0][63:0]  req_a;
    logic [N-1:0][63:0]  req_b;
    logic [N-1:0]        req_ready;
    logic [N-1:0]        resp_valid;
    logic [63:0]         resp_sum;
    logic                resp_cout;
    logic [IW-1:0]       resp_id;
    logic                busy;

    always #5 clk = ~clk;

    adder_share_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one job at a time, accepted in rotation, answered
    // 3 cycles after accept (4 when the low halves carry).
    int          cyc = 0;
    bit          m_pend = 0;
    int          m_acc, m_lat, m_id;
    int          m_last = N - 1;
    logic [63:0] m_sum;
    logic        m_co;
    logic [63:0] h_sum = '0;
    logic        h_co = 1'b0;
    int          h_id = 0;

    // Values observed on the DUT, for the directed checks.
    int          grant_log[$];
    int          o_acc, o_cyc, o_id;
    int          o_resp_cnt = 0;
    logic [63:0] o_sum;
    logic        o_co;

    function automatic int rr_next(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic step();
        logic [N-1:0] e_ready;
        logic [N-1:0] e_resp;
        logic [32:0]  lo;
        bit           e_busy;
        int           w;
        @(negedge clk);
        e_ready = '0;
        e_resp  = '0;
        w       = -1;
        if (!m_pend && !reset) begin
            w = rr_next(req_valid, m_last);
            if (w >= 0) e_ready[w] = 1'b1;
        end
        e_busy = m_pend && (cyc > m_acc);
        if (m_pend && cyc == m_acc + m_lat) begin
            e_resp[m_id] = 1'b1;
            h_sum = m_sum;
            h_co  = m_co;
            h_id  = m_id;
        end
        check("req_ready", req_ready, e_ready);
        check("resp_valid", resp_valid, e_resp);
        check("busy", busy, e_busy);
        check("resp_sum", resp_sum, h_sum);
        check("resp_cout", resp_cout, h_co);
        check("resp_id", resp_id, h_id);

        for (int i = 0; i < N; i++) begin
            if (req_ready[i]) begin
                grant_log.push_back(i);
                o_acc = cyc;
            end
        end
        if (resp_valid != 0) begin
            o_resp_cnt++;
            o_cyc = cyc;
            o_sum = resp_sum;
            o_co  = resp_cout;
            o_id  = int'(resp_id);
        end

        if (reset) begin
            m_pend = 0;
            m_last = N - 1;
            h_sum  = '0;
            h_co   = 1'b0;
            h_id   = 0;
        end else if (e_resp != 0) begin
            m_pend = 0;
            m_last = m_id;
        end else if (w >= 0) begin
            m_pend = 1;
            m_acc  = cyc;
            m_id   = w;
            {m_co, m_sum} = {1'b0, req_a[w]} + {1'b0, req_b[w]};
            lo     = {1'b0, req_a[w][31:0]} + {1'b0, req_b[w][31:0]};
            m_lat  = lo[32] ? 4 : 3;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i] = {$urandom, $urandom};
            req_b[i] = {$urandom, $urandom};
            if ($urandom_range(3) == 0) req_a[i][31:0] = 32'hFFFF_FFFF;
            if ($urandom_range(7) == 0) req_a[i][63:32] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    logic [63:0] t6_a, t6_b;
    int          cnt_before;

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // 1: reset, then idle with everything at 0
        do_reset();
        step();

        // 2: 1 + 1 on requester 0
        req_valid = 4'b0001;
        req_a[0]  = 64'd1;
        req_b[0]  = 64'd1;
        step();
        req_valid = '0;
        rand_ops();
        repeat (5) step();
        check("t2_sum", o_sum, 64'd2);
        check("t2_cout", o_co, 1'b0);
        check("t2_id", o_id, 0);
        check("t2_lat", o_cyc - o_acc, 3);

        // 3: carry from the low half needs the extra pass
        req_valid = 4'b0010;
        req_a[1]  = 64'h0000_0000_FFFF_FFFF;
        req_b[1]  = 64'd1;
        step();
        req_valid = '0;
        rand_ops();
        repeat (6) step();
        check("t3_sum", o_sum, 64'h0000_0001_0000_0000);
        check("t3_cout", o_co, 1'b0);
        check("t3_id", o_id, 1);
        check("t3_lat", o_cyc - o_acc, 4);

        // 4: full 64-bit overflow
        req_valid = 4'b0100;
        req_a[2]  = 64'hFFFF_FFFF_FFFF_FFFF;
        req_b[2]  = 64'd1;
        step();
        req_valid = '0;
        rand_ops();
        repeat (6) step();
        check("t4_sum", o_sum, 64'd0);
        check("t4_cout", o_co, 1'b1);
        check("t4_id", o_id, 2);
        check("t4_lat", o_cyc - o_acc, 4);

        // 5: all requesters held valid -> strict rotation from 0
        do_reset();
        grant_log.delete();
        req_valid = 4'b1111;
        repeat (28) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        repeat (6) step();
        check("t5_grants", grant_log.size() >= 5, 1'b1);
        if (grant_log.size() >= 5) begin
            check("t5_g0", grant_log[0], 0);
            check("t5_g1", grant_log[1], 1);
            check("t5_g2", grant_log[2], 2);
            check("t5_g3", grant_log[3], 3);
            check("t5_g4", grant_log[4], 0);
        end

        // 6: reset during ADD_HI aborts silently
        cnt_before = o_resp_cnt;
        req_valid  = 4'b1000;
        rand_ops();
        step();                 // accept
        req_valid = '0;
        step();                 // ADD_LO
        reset = 1'b1;
        step();                 // ADD_HI with reset
        reset = 1'b0;
        check("t6_busy", busy, 1'b0);
        repeat (6) step();
        check("t6_no_resp", o_resp_cnt, cnt_before);
        t6_a      = {$urandom, $urandom};
        t6_b      = {$urandom, $urandom};
        req_valid = 4'b0001;
        req_a[0]  = t6_a;
        req_b[0]  = t6_b;
        step();
        req_valid = '0;
        rand_ops();
        repeat (6) step();
        check("t6_sum", o_sum, t6_a + t6_b);
        check("t6_id", o_id, 0);
        check("t6_resp_cnt", o_resp_cnt, cnt_before + 1);

        // Random traffic with occasional reset
        for (int c = 0; c < 500; c++) begin
            rand_ops();
            for (int i = 0; i < N; i++) req_valid[i] = ($urandom_range(2) != 0);
            reset = ($urandom_range(99) == 0);
            step();
        end
        reset     = 1'b0;
        req_valid = '0;
        repeat (6) step();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
